// File: rtl/wait_sample_accum.sv
// Thread-style accumulator: waits WAIT_CYCLES clocks, samples in_data once, and after
// NUM_SAMPLES samples presents the signed sum on a registered valid/ready output.
module wait_sample_accum #(
    parameter int WIDTH       = 32,
    parameter int ACC_WIDTH   = 34,
    parameter int WAIT_CYCLES = 4,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic [1:0]                  state_o
);

    localparam int WC_W  = $clog2(WAIT_CYCLES + 1);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("WAIT_CYCLES must be >= 1");
        end
        if (NUM_SAMPLES < 1) begin : g_bad_samples
            $error("NUM_SAMPLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_SAMPLE = 2'd1,
        S_WAIT   = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    // Output handshake: a word transfers on any rising edge where out_valid and out_ready
    // are both high; out_valid then stays high with out_data stable until that transfer.
    state_t                        state_q, state_d;
    state_t                        after_wait_q, after_wait_d;
    logic [WC_W-1:0]               wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]              sample_cnt_q, sample_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [ACC_WIDTH-1:0]   in_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic [CNT_W-1:0]              cnt_inc;

    assign in_ext  = ACC_WIDTH'(in_data);
    assign sum     = acc_q + in_ext;
    assign cnt_inc = sample_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            after_wait_q <= S_INIT;
            wait_cnt_q   <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            after_wait_q <= after_wait_d;
            wait_cnt_q   <= wait_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        after_wait_d = after_wait_q;
        wait_cnt_d   = wait_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        unique case (state_q)
            S_INIT: begin
                acc_d        = '0;
                sample_cnt_d = '0;
                wait_cnt_d   = WC_W'(WAIT_CYCLES);
                after_wait_d = S_SAMPLE;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_d == '0) begin
                    state_d = after_wait_q;
                end
            end
            S_SAMPLE: begin
                sample_cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(NUM_SAMPLES)) begin
                    out_data_d  = sum;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    acc_d        = sum;
                    wait_cnt_d   = WC_W'(WAIT_CYCLES);
                    after_wait_d = S_SAMPLE;
                    state_d      = S_WAIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_wait_sample_accum.sv
// Directed bench for wait_sample_accum: cycle 0 is the first period after reset release,
// outputs are checked on the falling edge of each cycle.
module tb_wait_sample_accum;

    logic               clk;
    logic               reset;
    logic signed [31:0] in_data;
    logic               out_ready;
    logic [33:0]        out_data;
    logic               out_valid;
    logic [1:0]         state_o;

    int checks;
    int errors;
    int cyc;

    wait_sample_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_data = 32'sd5;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state_o);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 34'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
    endtask

    task automatic test_const_one();
        logic want_v;
        do_reset();
        in_data = 32'sd1;
        out_ready = 1'b1;
        while (cyc <= 44) begin
            want_v = (cyc == 21) || (cyc == 43);
            checks++;
            if (out_valid !== want_v) begin
                errors++;
                $display("FAIL const_valid cyc %0d got %b want %b", cyc, out_valid, want_v);
            end
            if (want_v) begin
                checks++;
                if (out_data !== 34'd4 || state_o !== 2'd3) begin
                    errors++;
                    $display("FAIL const_emit cyc %0d got data %h state %0d want 4 state 3",
                             cyc, out_data, state_o);
                end
            end
            if (cyc == 5 || cyc == 10 || cyc == 15 || cyc == 20) begin
                checks++;
                if (state_o !== 2'd1) begin
                    errors++;
                    $display("FAIL const_sample_state cyc %0d got %0d want 1", cyc, state_o);
                end
            end
            if (cyc == 1 || cyc == 4 || cyc == 22) begin
                checks++;
                if (state_o !== (cyc == 22 ? 2'd0 : 2'd2)) begin
                    errors++;
                    $display("FAIL const_state cyc %0d got %0d", cyc, state_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_arith();
        logic signed [31:0] vals [3];
        logic [33:0]        exps [3];
        vals[0] = -32'sd3;        exps[0] = 34'h3_FFFF_FFF4;
        vals[1] = 32'h7FFF_FFFF;  exps[1] = 34'h1_FFFF_FFFC;
        vals[2] = 32'h8000_0000;  exps[2] = 34'h2_0000_0000;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            in_data = vals[i];
            out_ready = 1'b1;
            while (cyc < 21) next_cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exps[i]) begin
                errors++;
                $display("FAIL arith_%0d got valid %b data %h want 1 %h",
                         i, out_valid, out_data, exps[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data = 32'sd1;
        out_ready = 1'b0;
        while (cyc < 21) next_cycle();
        while (cyc <= 30) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 34'd4 || state_o !== 2'd3) begin
                errors++;
                $display("FAIL hold cyc %0d got valid %b data %h state %0d want 1 4 3",
                         cyc, out_valid, out_data, state_o);
            end
            in_data = $signed(32'($urandom_range(1000, 0)));
            next_cycle();
        end
        out_ready = 1'b1;
        next_cycle();
        checks++;
        if (out_valid !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL release cyc %0d got valid %b state %0d want 0 0",
                     cyc, out_valid, state_o);
        end
    endtask

    task automatic test_wait_ignored();
        do_reset();
        out_ready = 1'b1;
        while (cyc < 21) begin
            in_data = (cyc == 5 || cyc == 10 || cyc == 15 || cyc == 20) ? 32'sd1 : 32'sd99;
            next_cycle();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 34'd4) begin
            errors++;
            $display("FAIL wait_ignored got valid %b data %h want 1 4", out_valid, out_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_data = 32'sd7;
        out_ready = 1'b1;
        while (cyc < 12) next_cycle();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got valid %b state %0d want 0 0", out_valid, state_o);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        in_data = 32'sd2;
        while (cyc <= 21) begin
            checks++;
            if (out_valid !== (cyc == 21)) begin
                errors++;
                $display("FAIL post_reset_valid cyc %0d got %b", cyc, out_valid);
            end
            if (cyc == 21) begin
                checks++;
                if (out_data !== 34'd8) begin
                    errors++;
                    $display("FAIL post_reset_sum got %h want 8", out_data);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_emit();
        do_reset();
        in_data = 32'sd3;
        out_ready = 1'b0;
        while (cyc < 24) next_cycle();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 34'h0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL emit_reset got valid %b data %h state %0d want 0 0 0",
                     out_valid, out_data, state_o);
        end
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        test_reset();
        test_const_one();
        test_arith();
        test_backpressure();
        test_wait_ignored();
        test_mid_reset();
        test_reset_in_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
